// File: rtl/frog_ctrl.sv
// frog_ctrl: frog lane position, timed hops, collisions, lives, respawn, scoring and game over.
module frog_ctrl #(
  parameter int ROW_W          = 3,
  parameter int NUM_ROWS       = 8,
  parameter int HOP_CYCLES     = 4,
  parameter int RESPAWN_CYCLES = 16,
  parameter int MAX_LIVES      = 3,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_dir,
  input  logic             key_valid,
  input  logic             hit,
  input  logic             game_en,
  output logic [ROW_W-1:0] frog_row,
  output logic             hopping,
  output logic             dead,
  output logic [1:0]       lives,
  output logic [7:0]       score,
  output logic             win,
  output logic             game_over
);
  typedef enum logic [2:0] {S_IDLE, S_READY, S_HOP, S_DEAD, S_OVER} state_t;
  localparam logic [ROW_W-1:0] LAST = ROW_W'(NUM_ROWS - 1);
  state_t r_state, w_state;
  logic [CNT_W-1:0] r_timer, w_timer;
  logic [ROW_W-1:0] w_row;
  logic [1:0] w_lives;
  logic [7:0] w_score;
  logic w_hop, w_dead, w_win, w_over, w_hit, w_last_life;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      frog_row  <= '0;
      hopping   <= 1'b0;
      dead      <= 1'b0;
      lives     <= 2'(MAX_LIVES);
      score     <= '0;
      win       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_timer   <= w_timer;
      frog_row  <= w_row;
      hopping   <= w_hop;
      dead      <= w_dead;
      lives     <= w_lives;
      score     <= w_score;
      win       <= w_win;
      game_over <= w_over;
    end
  end
  always_comb begin
    w_state     = r_state;
    w_timer     = r_timer;
    w_row       = frog_row;
    w_hop       = hopping;
    w_dead      = dead;
    w_lives     = lives;
    w_score     = score;
    w_win       = 1'b0;
    w_over      = game_over;
    w_last_life = lives <= 2'd1;
    // Start and goal rows are safe; a hit outranks any key or hop completion.
    w_hit = hit && frog_row != '0 && frog_row != LAST && (r_state == S_READY || r_state == S_HOP);
    if (!game_en) begin
      w_state = S_IDLE;
      w_timer = '0;
      w_row   = '0;
      w_hop   = 1'b0;
      w_dead  = 1'b0;
      w_over  = 1'b0;
    end else if (w_hit) begin
      w_lives = lives - {1'b0, |lives};
      w_hop   = 1'b0;
      w_state = w_last_life ? S_OVER : S_DEAD;
      w_dead  = !w_last_life;
      w_over  = w_last_life;
      w_timer = w_last_life ? '0 : CNT_W'(RESPAWN_CYCLES - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state = S_READY;
          w_row   = '0;
          w_lives = 2'(MAX_LIVES);
          w_score = '0;
        end
        S_READY: if (key_valid && (key_dir ? frog_row != '0 : frog_row != LAST)) begin
          w_row   = key_dir ? frog_row - 1'b1 : frog_row + 1'b1;
          w_hop   = 1'b1;
          w_timer = CNT_W'(HOP_CYCLES - 1);
          w_state = S_HOP;
        end
        S_HOP: if (r_timer == '0) begin
          w_hop   = 1'b0;
          w_state = S_READY;
          if (frog_row == LAST) begin
            w_win   = 1'b1;
            w_score = score + {7'd0, score != 8'hff};
            w_row   = '0;
          end
        end else w_timer = r_timer - 1'b1;
        S_DEAD: if (r_timer == '0) begin
          w_dead  = 1'b0;
          w_row   = '0;
          w_state = S_READY;
        end else w_timer = r_timer - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_frog_ctrl.sv
// tb_frog_ctrl: directed-vector bench for frog_ctrl with default parameters.
module tb_frog_ctrl;
  logic clk = 1'b0, rst = 1'b1, key_dir = 1'b0, key_valid = 1'b0, hit = 1'b0, game_en = 1'b0;
  logic [2:0] frog_row;
  logic hopping, dead, win, game_over;
  logic [1:0] lives;
  logic [7:0] score;
  int vecs = 0, errs = 0;

  frog_ctrl dut (.clk(clk), .rst(rst), .key_dir(key_dir), .key_valid(key_valid), .hit(hit),
    .game_en(game_en), .frog_row(frog_row), .hopping(hopping), .dead(dead), .lives(lives),
    .score(score), .win(win), .game_over(game_over));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic d);
    key_dir = d;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic hop_up();
    key(1'b0);
    repeat (4) tick();
  endtask

  task automatic restart();
    game_en = 1'b0;
    tick();
    game_en = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++; if (frog_row !== 3'd0) begin errs++; $display("FAIL reset_row got %0d exp 0", frog_row); end
    vecs++; if (hopping !== 1'b0) begin errs++; $display("FAIL reset_hopping got %0d exp 0", hopping); end
    vecs++; if (dead !== 1'b0) begin errs++; $display("FAIL reset_dead got %0d exp 0", dead); end
    vecs++; if (lives !== 2'd3) begin errs++; $display("FAIL reset_lives got %0d exp 3", lives); end
    vecs++; if (score !== 8'd0) begin errs++; $display("FAIL reset_score got %0d exp 0", score); end
    vecs++; if (win !== 1'b0) begin errs++; $display("FAIL reset_win got %0d exp 0", win); end
    vecs++; if (game_over !== 1'b0) begin errs++; $display("FAIL reset_over got %0d exp 0", game_over); end
    game_en = 1'b1;
    tick();
  endtask

  task automatic test_hop();
    key(1'b0);
    vecs++; if (frog_row !== 3'd1) begin errs++; $display("FAIL hop_row got %0d exp 1", frog_row); end
    vecs++; if (hopping !== 1'b1) begin errs++; $display("FAIL hop_start got %0d exp 1", hopping); end
    key(1'b0);
    vecs++; if (frog_row !== 3'd1) begin errs++; $display("FAIL hop_drop_key got %0d exp 1", frog_row); end
    repeat (2) tick();
    vecs++; if (hopping !== 1'b1) begin errs++; $display("FAIL hop_last_cycle got %0d exp 1", hopping); end
    tick();
    vecs++; if (hopping !== 1'b0) begin errs++; $display("FAIL hop_end got %0d exp 0", hopping); end
    vecs++; if (frog_row !== 3'd1) begin errs++; $display("FAIL hop_final_row got %0d exp 1", frog_row); end
  endtask

  task automatic test_goal();
    restart();
    for (int i = 0; i < 6; i++) begin
      key(1'b0);
      vecs++; if (frog_row !== 3'(i + 1)) begin errs++; $display("FAIL goal_climb got %0d exp %0d", frog_row, i + 1); end
      repeat (5) tick();
    end
    key(1'b0);
    vecs++; if (frog_row !== 3'd7) begin errs++; $display("FAIL goal_row got %0d exp 7", frog_row); end
    repeat (3) tick();
    vecs++; if (win !== 1'b0) begin errs++; $display("FAIL goal_early_win got %0d exp 0", win); end
    tick();
    vecs++; if (win !== 1'b1) begin errs++; $display("FAIL goal_win got %0d exp 1", win); end
    vecs++; if (score !== 8'd1) begin errs++; $display("FAIL goal_score got %0d exp 1", score); end
    vecs++; if (frog_row !== 3'd0) begin errs++; $display("FAIL goal_return got %0d exp 0", frog_row); end
    tick();
    vecs++; if (win !== 1'b0) begin errs++; $display("FAIL goal_win_pulse got %0d exp 0", win); end
  endtask

  task automatic test_down();
    key(1'b1);
    vecs++; if (frog_row !== 3'd0) begin errs++; $display("FAIL down_row0 got %0d exp 0", frog_row); end
    vecs++; if (hopping !== 1'b0) begin errs++; $display("FAIL down_row0_hop got %0d exp 0", hopping); end
    hop_up();
    hop_up();
    key(1'b1);
    vecs++; if (frog_row !== 3'd1) begin errs++; $display("FAIL down_row2 got %0d exp 1", frog_row); end
    vecs++; if (hopping !== 1'b1) begin errs++; $display("FAIL down_hop got %0d exp 1", hopping); end
    repeat (4) tick();
  endtask

  task automatic test_hit();
    logic dead_ok;
    hop_up();
    hop_up();
    hit = 1'b1;
    tick();
    hit = 1'b0;
    vecs++; if (lives !== 2'd2) begin errs++; $display("FAIL hit_lives got %0d exp 2", lives); end
    vecs++; if (frog_row !== 3'd3) begin errs++; $display("FAIL hit_row_held got %0d exp 3", frog_row); end
    dead_ok = dead;
    repeat (15) begin
      tick();
      dead_ok = dead_ok & dead;
    end
    vecs++; if (dead_ok !== 1'b1) begin errs++; $display("FAIL hit_dead_span got %0d exp 1", dead_ok); end
    tick();
    vecs++; if (dead !== 1'b0) begin errs++; $display("FAIL hit_respawn got %0d exp 0", dead); end
    vecs++; if (frog_row !== 3'd0) begin errs++; $display("FAIL hit_respawn_row got %0d exp 0", frog_row); end
    hop_up();
    vecs++; if (frog_row !== 3'd1) begin errs++; $display("FAIL hit_rekey got %0d exp 1", frog_row); end
    key(1'b1);
    repeat (4) tick();
    hit = 1'b1;
    tick();
    hit = 1'b0;
    vecs++; if (lives !== 2'd2) begin errs++; $display("FAIL hit_row0_lives got %0d exp 2", lives); end
    vecs++; if (dead !== 1'b0) begin errs++; $display("FAIL hit_row0_dead got %0d exp 0", dead); end
  endtask

  task automatic test_over();
    restart();
    for (int i = 0; i < 3; i++) begin
      hop_up();
      hop_up();
      hit = 1'b1;
      tick();
      hit = 1'b0;
      vecs++; if (lives !== 2'(2 - i)) begin errs++; $display("FAIL over_lives got %0d exp %0d", lives, 2 - i); end
      if (i < 2) repeat (16) tick();
    end
    vecs++; if (game_over !== 1'b1) begin errs++; $display("FAIL over_flag got %0d exp 1", game_over); end
    vecs++; if (dead !== 1'b0) begin errs++; $display("FAIL over_dead got %0d exp 0", dead); end
    key(1'b0);
    tick();
    vecs++; if (frog_row !== 3'd2) begin errs++; $display("FAIL over_key_drop got %0d exp 2", frog_row); end
    vecs++; if (lives !== 2'd0) begin errs++; $display("FAIL over_no_underflow got %0d exp 0", lives); end
    game_en = 1'b0;
    tick();
    vecs++; if (game_over !== 1'b0) begin errs++; $display("FAIL over_idle got %0d exp 0", game_over); end
    vecs++; if (lives !== 2'd0) begin errs++; $display("FAIL over_idle_lives got %0d exp 0", lives); end
    game_en = 1'b1;
    tick();
    vecs++; if (lives !== 2'd3) begin errs++; $display("FAIL over_restart_lives got %0d exp 3", lives); end
    vecs++; if (score !== 8'd0) begin errs++; $display("FAIL over_restart_score got %0d exp 0", score); end
    vecs++; if (frog_row !== 3'd0) begin errs++; $display("FAIL over_restart_row got %0d exp 0", frog_row); end
  endtask

  task automatic test_back_to_back();
    hop_up();
    hop_up();
    hit = 1'b1;
    key_dir = 1'b0;
    key_valid = 1'b1;
    tick();
    hit = 1'b0;
    key_valid = 1'b0;
    vecs++; if (lives !== 2'd2) begin errs++; $display("FAIL b2b_lives got %0d exp 2", lives); end
    vecs++; if (frog_row !== 3'd2) begin errs++; $display("FAIL b2b_row got %0d exp 2", frog_row); end
    vecs++; if (dead !== 1'b1) begin errs++; $display("FAIL b2b_dead got %0d exp 1", dead); end
    vecs++; if (hopping !== 1'b0) begin errs++; $display("FAIL b2b_hopping got %0d exp 0", hopping); end
  endtask

  task automatic test_rst_midhop();
    repeat (16) tick();
    key(1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++; if (frog_row !== 3'd0) begin errs++; $display("FAIL rst_row got %0d exp 0", frog_row); end
    vecs++; if (hopping !== 1'b0) begin errs++; $display("FAIL rst_hopping got %0d exp 0", hopping); end
    vecs++; if (dead !== 1'b0) begin errs++; $display("FAIL rst_dead got %0d exp 0", dead); end
    vecs++; if (lives !== 2'd3) begin errs++; $display("FAIL rst_lives got %0d exp 3", lives); end
    vecs++; if (win !== 1'b0) begin errs++; $display("FAIL rst_win got %0d exp 0", win); end
    vecs++; if (game_over !== 1'b0) begin errs++; $display("FAIL rst_over got %0d exp 0", game_over); end
  endtask

  initial begin
    test_reset();
    test_hop();
    test_goal();
    test_down();
    test_hit();
    test_over();
    test_back_to_back();
    test_rst_midhop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
